// File: rtl/iter_muldiv_if.sv
// iter_muldiv_if: request/result handshake bundle for the iterative multiply/divide unit
interface iter_muldiv_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            dz;
    logic            busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, dz, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, dz, busy
    );
endinterface

// File: rtl/iter_muldiv.sv
// iter_muldiv: radix-2 iterative multiply / restoring divide with valid/ready handshakes
module iter_muldiv #(
    parameter int XLEN   = 64,
    parameter bit DIV_EN = 1'b1
) (
    input logic          clk,
    input logic          rst,
    iter_muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_SMULH = 3'd1;
    localparam logic [2:0] OP_SDIV  = 3'd3;
    localparam logic [2:0] OP_UDIV  = 3'd4;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] p_q, p_d;
    logic [XLEN-1:0]   m_q, m_d;
    logic              neg_q, neg_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              dz_q, dz_d;

    logic              is_sgn, is_div, legal, a_neg, b_neg, div_q;
    logic [XLEN-1:0]   a_mag, b_mag, quo;
    logic [2*XLEN-1:0] prod;

    // One radix-2 step: p holds {hi, lo}. Multiply adds m into hi when lo[0]
    // is set and shifts right; divide shifts left and subtracts m from the
    // partial remainder in hi, feeding quotient bits into lo.
    function automatic logic [2*XLEN-1:0] step(input logic [2*XLEN-1:0] p,
                                                input logic [XLEN-1:0] m,
                                                input logic div);
        logic [XLEN:0] sum, sh, diff;
        sum  = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : '0);
        sh   = {p[2*XLEN-1:XLEN], p[XLEN-1]};
        diff = sh - {1'b0, m};
        return !div ? {sum, p[XLEN-1:1]}
             : diff[XLEN] ? {sh[XLEN-1:0], p[XLEN-2:0], 1'b0}
             : {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
    endfunction

    assign is_sgn = bus.op == OP_SMULH || bus.op == OP_SDIV;
    assign is_div = DIV_EN && (bus.op == OP_SDIV || bus.op == OP_UDIV);
    assign legal  = bus.op < 3'd3 || is_div;
    assign a_neg  = is_sgn && bus.a[XLEN-1];
    assign b_neg  = is_sgn && bus.b[XLEN-1];
    assign a_mag  = a_neg ? -bus.a : bus.a;
    assign b_mag  = b_neg ? -bus.b : bus.b;
    assign div_q  = DIV_EN && (op_q == OP_SDIV || op_q == OP_UDIV);
    assign prod   = neg_q ? -p_q : p_q;
    assign quo    = neg_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];

    // Outputs are pure decodes of registered state
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy      = state_q != IDLE;
    assign bus.result    = res_q;
    assign bus.dz        = dz_q;

    // Next-state and datapath; the first iteration happens on the accept edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        m_d     = m_q;
        neg_d   = neg_q;
        op_d    = op_q;
        res_d   = res_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                op_d  = bus.op;
                m_d   = b_mag;
                neg_d = a_neg ^ b_neg;
                cnt_d = CW'(1);
                p_d   = step({{XLEN{1'b0}}, a_mag}, b_mag, is_div);
                if (!legal || (is_div && bus.b == '0)) begin
                    state_d = DONE;
                    res_d   = '0;
                    dz_d    = legal;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                p_d     = step(p_q, m_q, div_q);
                cnt_d   = cnt_q + CW'(1);
                state_d = cnt_q == CW'(XLEN - 1) ? FIX : CALC;
            end
            FIX: begin
                res_d   = div_q ? quo : op_q == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                dz_d    = 1'b0;
                state_d = DONE;
            end
            default: state_d = bus.out_ready ? IDLE : DONE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            m_q     <= '0;
            neg_q   <= 1'b0;
            op_q    <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            m_q     <= m_d;
            neg_q   <= neg_d;
            op_q    <= op_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
        end
    end
endmodule

// File: tb/tb_iter_muldiv.sv
// tb_iter_muldiv: directed checks of the iterative multiply/divide unit at XLEN=64
module tb_iter_muldiv;
    localparam int XLEN = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    iter_muldiv_if #(.XLEN(XLEN)) bus ();

    iter_muldiv #(.XLEN(XLEN), .DIV_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request, waits for the accept edge, then scrambles the inputs
    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        chk("in_ready_before_issue", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op = 3'($urandom);
        bus.a = {$urandom, $urandom};
        bus.b = {$urandom, $urandom};
    endtask

    // Waits for out_valid, checks latency/result/dz, then completes the handshake
    task automatic expect_out(input string tag, input logic [63:0] res, input logic dz, input int lat_exp);
        int lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(lat_exp));
        chk({tag, "_result"}, bus.result, res);
        chk({tag, "_dz"}, 64'(bus.dz), 64'(dz));
        chk({tag, "_in_ready_done"}, 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_out_valid_after"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_in_ready_after"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_result_held"}, bus.result, res);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_dz", 64'(bus.dz), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);

        issue(3'd0, 64'd3, -64'd5);
        chk("busy_calc", 64'(bus.busy), 64'd1);
        expect_out("mul_3_m5", 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 65);

        issue(3'd2, ONES, ONES);
        expect_out("umulh_ones", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65);
        issue(3'd1, ONES, ONES);
        expect_out("smulh_m1_m1", 64'd0, 1'b0, 65);
        issue(3'd1, MIN, 64'd2);
        expect_out("smulh_min_2", ONES, 1'b0, 65);
        issue(3'd1, -64'd3, 64'd5);
        expect_out("smulh_m3_5", ONES, 1'b0, 65);
        issue(3'd2, 64'h1_0000_0000, 64'h1_0000_0000);
        expect_out("umulh_2p32_sq", 64'd1, 1'b0, 65);

        issue(3'd3, -64'd7, 64'd2);
        expect_out("sdiv_m7_2", 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65);
        issue(3'd4, 64'd100, 64'd7);
        expect_out("udiv_100_7", 64'd14, 1'b0, 65);
        issue(3'd3, MIN, ONES);
        expect_out("sdiv_min_m1", MIN, 1'b0, 65);
        issue(3'd3, 64'd7, -64'd2);
        expect_out("sdiv_7_m2", 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65);
        issue(3'd4, ONES, 64'd1);
        expect_out("udiv_ones_1", ONES, 1'b0, 65);

        issue(3'd4, 64'd5, 64'd0);
        expect_out("udiv_5_0", 64'd0, 1'b1, 1);
        issue(3'd3, -64'd5, 64'd0);
        expect_out("sdiv_m5_0", 64'd0, 1'b1, 1);
        issue(3'd6, 64'd9, 64'd9);
        expect_out("illegal_6", 64'd0, 1'b0, 1);
        issue(3'd5, 64'd9, 64'd3);
        expect_out("illegal_5", 64'd0, 1'b0, 1);

        issue(3'd0, 64'd6, 64'd7);
        repeat (64) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_result", bus.result, 64'd42);
            chk("hold_dz", 64'(bus.dz), 64'd0);
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        expect_out("hold_release", 64'd42, 1'b0, 1);

        issue(3'd4, 64'd1000, 64'd3);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        repeat (70) @(posedge clk);
        #1;
        chk("abort_no_output", 64'(bus.out_valid), 64'd0);
        issue(3'd4, 64'd100, 64'd7);
        expect_out("udiv_after_abort", 64'd14, 1'b0, 65);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
